// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port synchronous RAM
// Optional round-robin arbitration when MEM_PORT_ARB_RR_EN is defined.
module mem_port_arbiter #(
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_adr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   output logic        if_stall,
   input  logic        d_re,
   input  logic        d_we,
   input  logic [31:0] d_adr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wmask,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        d_stall,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE = 2'd0, RD_IF = 2'd1, RD_D = 2'd2} state_t;

   localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

   state_t     state, state_nx;
   logic [1:0] lat_cnt, lat_nx;
   logic       d_any, ret_cycle, slot, ret_if, ret_d;
   logic       grant_if, grant_d, wr_grant, rd_grant;
   logic       if_done, d_done, act;

`ifdef MEM_PORT_ARB_RR_EN
   logic       last_if, last_if_nx, hist, hist_nx;
`else
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   logic [3:0] starve_cnt, starve_nx;
`endif

   // A new access may be issued when idle or in the cycle the outstanding read returns.
   always_comb begin
      d_any     = d_re | d_we;
      ret_cycle = (state != IDLE) && (lat_cnt == 2'd0);
      slot      = (state == IDLE) || ret_cycle;
      ret_if    = ret_cycle && (state == RD_IF);
      ret_d     = ret_cycle && (state == RD_D);
`ifdef MEM_PORT_ARB_RR_EN
      if (if_req && d_any) begin
         grant_if = slot && hist && !last_if;
      end else begin
         grant_if = slot && if_req;
      end
`else
      grant_if  = slot && if_req && (!d_any || (starve_cnt == STARVE_MAX));
`endif
      grant_d   = slot && d_any && !grant_if;
      wr_grant  = grant_d && d_we;
      rd_grant  = grant_d && !d_we;
   end

   always_comb begin
      state_nx = state;
      lat_nx   = lat_cnt;
      if (slot) begin
         if (grant_if) begin
            state_nx = RD_IF;
            lat_nx   = LAT_LOAD;
         end else if (rd_grant) begin
            state_nx = RD_D;
            lat_nx   = LAT_LOAD;
         end else begin
            state_nx = IDLE;
         end
      end else if (lat_cnt != 2'd0) begin
         lat_nx = lat_cnt - 2'd1;
      end
   end

`ifdef MEM_PORT_ARB_RR_EN
   always_comb begin
      last_if_nx = last_if;
      hist_nx    = hist;
      if (grant_if || grant_d) begin
         last_if_nx = grant_if;
         hist_nx    = 1'b1;
      end
   end
`else
   // Counts data grants that overtook a waiting fetch.
   always_comb begin
      starve_nx = starve_cnt;
      if (!if_req || grant_if) begin
         starve_nx = 4'd0;
      end else if (grant_d && (starve_cnt != STARVE_MAX)) begin
         starve_nx = starve_cnt + 4'd1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         lat_cnt <= 2'd0;
`ifdef MEM_PORT_ARB_RR_EN
         last_if <= 1'b0;
         hist    <= 1'b0;
`else
         starve_cnt <= 4'd0;
`endif
      end else begin
         state   <= state_nx;
         lat_cnt <= lat_nx;
`ifdef MEM_PORT_ARB_RR_EN
         last_if <= last_if_nx;
         hist    <= hist_nx;
`else
         starve_cnt <= starve_nx;
`endif
      end
   end

   // Outputs are held at zero during reset so an abandoned read cannot leak through.
   always_comb begin
      act       = !rst;
      mem_en    = act && (grant_if || grant_d);
      mem_we    = act && wr_grant;
      mem_adr   = 32'd0;
      if (act && grant_if) begin
         mem_adr = if_adr;
      end else if (act && grant_d) begin
         mem_adr = d_adr;
      end
      mem_wdata = (act && wr_grant) ? d_wdata : 32'd0;
      mem_wmask = (act && wr_grant) ? d_wmask : 4'd0;
      if_valid  = act && ret_if && if_req;
      d_valid   = act && ret_d && d_re;
      if_rdata  = if_valid ? mem_rdata : 32'd0;
      d_rdata   = d_valid ? mem_rdata : 32'd0;
      if_done   = if_valid;
      d_done    = d_valid || (wr_grant && !d_re);
      if_stall  = act && if_req && !if_done;
      d_stall   = act && d_any && !d_done;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter with a cycle-numbered reference model
module tb_mem_port_arbiter;
   localparam int LAT  = 2;
   localparam int SLIM = 3;

   logic        clk = 1'b0;
   logic        rst, if_req, d_re, d_we;
   logic [31:0] if_adr, d_adr, d_wdata, mem_rdata;
   logic [3:0]  d_wmask;
   logic [31:0] if_rdata, d_rdata, mem_adr, mem_wdata;
   logic        if_valid, if_stall, d_valid, d_stall, mem_en, mem_we;
   logic [3:0]  mem_wmask;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_LIMIT(SLIM)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .d_re(d_re), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_wmask(d_wmask),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   int n_vec = 0;
   int n_bad = 0;
   int t = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, t);
      end
   endtask

   logic [31:0] ram [logic [31:0]];
   logic [31:0] sched [int];
   bit          obs_g[$];

   function automatic logic [31:0] ram_val(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   // Reference model: one outstanding read, tracked by owner and absolute return cycle.
   bit          m_busy, m_own_if, m_last_if, m_hist;
   int          m_ret, m_starve;
   logic [31:0] m_data;
   bit          m_is, m_ds;
   logic        s_en, s_we, s_iv, s_dv, s_is, s_ds;
   logic [31:0] s_adr, s_wd, s_ir;
   logic [3:0]  s_wm;

   task automatic model_check();
      bit slot, ret, d_any, fwin, dwin, wr;
      logic e_en, e_we, e_iv, e_dv, e_is, e_ds;
      logic [31:0] e_adr, e_wd, e_ir, e_dr;
      logic [3:0] e_wm;
      e_en = 0; e_we = 0; e_iv = 0; e_dv = 0; e_is = 0; e_ds = 0;
      e_adr = 0; e_wd = 0; e_ir = 0; e_dr = 0; e_wm = 0;
      if (rst) begin
         m_busy = 0; m_starve = 0; m_hist = 0; m_last_if = 0;
      end else begin
         ret   = m_busy && (t == m_ret);
         slot  = !m_busy || ret;
         d_any = d_re || d_we;
`ifdef MEM_PORT_ARB_RR_EN
         if (if_req && d_any) fwin = m_hist && !m_last_if;
         else fwin = if_req;
`else
         fwin = if_req && (!d_any || m_starve == SLIM);
`endif
         fwin  = fwin && slot;
         dwin  = slot && d_any && !fwin;
         wr    = dwin && d_we;
         e_en  = fwin || dwin;
         e_we  = wr;
         e_adr = fwin ? if_adr : (dwin ? d_adr : 32'd0);
         e_wd  = wr ? d_wdata : 32'd0;
         e_wm  = wr ? d_wmask : 4'd0;
         e_iv  = ret && m_own_if && if_req;
         e_dv  = ret && !m_own_if && d_re;
         e_ir  = e_iv ? m_data : 32'd0;
         e_dr  = e_dv ? m_data : 32'd0;
         e_is  = if_req && !e_iv;
         e_ds  = d_any && !(e_dv || (wr && !d_re));
         if (slot) begin
            m_busy = fwin || (dwin && !d_we);
            m_own_if = fwin;
            m_ret = t + LAT;
            m_data = ram_val(fwin ? if_adr : d_adr);
         end
         if (!if_req || fwin) m_starve = 0;
         else if (dwin && m_starve < SLIM) m_starve++;
         if (fwin || dwin) begin
            m_last_if = fwin;
            m_hist = 1;
         end
      end
      check("mem_en", 32'(mem_en), 32'(e_en));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_adr", mem_adr, e_adr);
      check("mem_wdata", mem_wdata, e_wd);
      check("mem_wmask", 32'(mem_wmask), 32'(e_wm));
      check("if_valid", 32'(if_valid), 32'(e_iv));
      check("if_rdata", if_rdata, e_ir);
      check("d_valid", 32'(d_valid), 32'(e_dv));
      check("d_rdata", d_rdata, e_dr);
      check("if_stall", 32'(if_stall), 32'(e_is));
      check("d_stall", 32'(d_stall), 32'(e_ds));
      m_is = e_is;
      m_ds = e_ds;
   endtask

   task automatic tick();
      if (sched.exists(t)) begin
         mem_rdata = sched[t];
         sched.delete(t);
      end else begin
         mem_rdata = $urandom;
      end
      @(negedge clk);
      model_check();
      s_en = mem_en; s_we = mem_we; s_adr = mem_adr; s_wd = mem_wdata; s_wm = mem_wmask;
      s_iv = if_valid; s_ir = if_rdata; s_dv = d_valid; s_is = if_stall; s_ds = d_stall;
      if (mem_en && !mem_we) sched[t + LAT] = ram_val(mem_adr);
      if (mem_en) obs_g.push_back(mem_adr == if_adr && if_req && !mem_we);
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic quiet_reset();
      if_req = 0; d_re = 0; d_we = 0; rst = 1;
      tick();
      rst = 0;
      obs_g.delete();
   endtask

   initial begin
      bit seen;
      ram[32'h100] = 32'h0000_0013;
      rst = 1; if_req = 0; d_re = 0; d_we = 0;
      if_adr = 0; d_adr = 0; d_wdata = 0; d_wmask = 0; mem_rdata = 0;
      #1;
      tick();
      check("reset_mem_en", 32'(s_en), 32'd0);
      check("reset_if_stall", 32'(s_is), 32'd0);
      rst = 0;
      tick();

      // lone fetch, then a re-granted fetch dropped before its return
      quiet_reset();
      if_req = 1; if_adr = 32'h100;
      tick();
      check("f1_issue", 32'(s_en), 32'd1);
      check("f1_stall_c0", 32'(s_is), 32'd1);
      tick();
      check("f1_wait_en", 32'(s_en), 32'd0);
      tick();
      check("f1_valid", 32'(s_iv), 32'd1);
      check("f1_rdata", s_ir, 32'h13);
      check("f1_stall_ret", 32'(s_is), 32'd0);
      if_req = 0;
      tick();
      tick();
      check("f1_drop_novalid", 32'(s_iv), 32'd0);

      // simultaneous fetch and data read from idle
      quiet_reset();
      if_req = 1; if_adr = 32'h100; d_re = 1; d_adr = 32'h2000;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (s_iv) seen = 1;
      end
      check("both_fetch_done", 32'(seen), 32'd1);
      if_req = 0;
      check("both_first_data", 32'(obs_g.size() > 0 ? obs_g[0] : 1'b1), 32'd0);
`ifdef MEM_PORT_ARB_RR_EN
      check("rr_second_fetch", 32'(obs_g.size() > 1 ? obs_g[1] : 1'b0), 32'd1);
      check("rr_third_data", 32'(obs_g.size() > 2 ? obs_g[2] : 1'b1), 32'd0);
`else
      check("starve_grants", 32'(obs_g.size()), 32'd5);
      check("starve_g1", 32'(obs_g.size() > 1 ? obs_g[1] : 1'b1), 32'd0);
      check("starve_g2", 32'(obs_g.size() > 2 ? obs_g[2] : 1'b1), 32'd0);
      check("starve_g3_fetch", 32'(obs_g.size() > 3 ? obs_g[3] : 1'b0), 32'd1);
`endif
      for (int i = 0; i < 6; i++) tick();
      d_re = 0;
      tick();
      tick();

      // write alongside a waiting fetch
      quiet_reset();
      d_we = 1; d_adr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
      if_req = 1; if_adr = 32'h300;
      tick();
      check("wr_we", 32'(s_we), 32'd1);
      check("wr_mask", 32'(s_wm), 32'h3);
      check("wr_data", s_wd, 32'hDEAD_BEEF);
      check("wr_dstall", 32'(s_ds), 32'd0);
      d_we = 0;
      tick();
      check("wr_fetch_next", s_adr, 32'h300);
      if_req = 0;
      tick();
      tick();

      // reset while a fetch is outstanding
      quiet_reset();
      if_req = 1; if_adr = 32'h100;
      tick();
      rst = 1; d_re = 1; d_adr = 32'h80;
      tick();
      check("rst_out_en", 32'(s_en), 32'd0);
      check("rst_out_stall", 32'(s_is | s_ds), 32'd0);
      rst = 0; if_req = 0; d_re = 0;
      tick();
      check("rst_no_valid", 32'(s_iv), 32'd0);
      tick();

      // randomized traffic obeying the hold-while-stalled protocol
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (!m_is) begin
            if_req = ($urandom_range(0, 2) != 0);
            if_adr = {20'd0, 4'($urandom_range(0, 7)), 8'h00};
         end else if ($urandom_range(0, 63) == 0) begin
            if_req = 0;
         end
         if (!m_ds) begin
            case ($urandom_range(0, 3))
               0: begin d_re = 0; d_we = 0; end
               1: begin d_re = 0; d_we = 1; end
               default: begin d_re = 1; d_we = 0; end
            endcase
            d_adr   = {16'h0001, 8'($urandom), 6'($urandom), 2'b00};
            d_wdata = $urandom;
            d_wmask = 4'($urandom);
         end
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
